// File: rtl/mm_compute_sequencer_if.sv
// Stream, register-file, MAC-control and output-controller signals of the
// 4x4 A*A^T compute sequencer, bundled for a single port connection.
interface mm_compute_sequencer_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    sel_i;
    logic [1:0]    sel_j;
    logic [1:0]    sel_k;
    logic          acc_en;
    logic          acc_clr;
    logic          acc_store;
    logic [3:0]    store_sel;
    logic          out_busy;
    logic          cf_load;
    logic          busy;

    // Sequencer side
    modport master (
        input  in_valid, in_data, out_busy,
        output in_ready, wr_en, wr_addr, wr_data,
               sel_i, sel_j, sel_k, acc_en, acc_clr,
               acc_store, store_sel, cf_load, busy
    );

    // Environment side: input stream source, datapath and output controller
    modport slave (
        output in_valid, in_data, out_busy,
        input  in_ready, wr_en, wr_addr, wr_data,
               sel_i, sel_j, sel_k, acc_en, acc_clr,
               acc_store, store_sel, cf_load, busy
    );
endinterface

// File: rtl/mm_compute_sequencer.sv
// Front-end controller for the 4x4 matrix multiplier: loads A (16 elements,
// row-major) into the register file, then issues the 40 MAC operand sets for
// the upper triangle of C = A*A^T, schedules the 10 result stores MAC_LAT
// cycles after each entry's last term, and pulses cf_load to start the
// output controller once it is free.
module mm_compute_sequencer #(
    parameter int DW      = 8,
    parameter int MAC_LAT = 2   // legal range 1..7
) (
    input  logic                  CLK,
    input  logic                  reset,
    mm_compute_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_LOAD,
        S_COMP,
        S_DRAIN,
        S_WAIT_OUT,
        S_FIRE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [1:0]  k_cnt_q, k_cnt_d;
    logic [3:0]  entry_q, entry_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic [1:0]  sel_i_q, sel_i_d;
    logic [1:0]  sel_j_q, sel_j_d;
    logic [1:0]  sel_k_q, sel_k_d;
    logic        acc_en_q, acc_en_d;
    logic        acc_clr_q, acc_clr_d;
    logic        cf_load_q, cf_load_d;
    logic        busy_q, busy_d;
    // Store delay line: stage MAC_LAT-1 drives acc_store/store_sel
    logic        pipe_vld_q [MAC_LAT];
    logic        pipe_vld_d [MAC_LAT];
    logic [3:0]  pipe_sel_q [MAC_LAT];
    logic [3:0]  pipe_sel_d [MAC_LAT];

    logic          in_ready_w;
    logic          wr_en_w;
    logic [DW-1:0] in_data_w;

    // Upper-triangle visiting order: entry p -> {i, j}
    function automatic logic [3:0] entry_pair(input logic [3:0] e);
        case (e)
            4'd0:    entry_pair = {2'd0, 2'd0};
            4'd1:    entry_pair = {2'd0, 2'd1};
            4'd2:    entry_pair = {2'd0, 2'd2};
            4'd3:    entry_pair = {2'd0, 2'd3};
            4'd4:    entry_pair = {2'd1, 2'd1};
            4'd5:    entry_pair = {2'd1, 2'd2};
            4'd6:    entry_pair = {2'd1, 2'd3};
            4'd7:    entry_pair = {2'd2, 2'd2};
            4'd8:    entry_pair = {2'd2, 2'd3};
            default: entry_pair = {2'd3, 2'd3};
        endcase
    endfunction

    assign in_ready_w = (state_q == S_LOAD);
    assign wr_en_w    = bus.in_valid & in_ready_w;
    assign in_data_w  = bus.in_data;

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        k_cnt_d     = k_cnt_q;
        entry_d     = entry_q;
        drain_cnt_d = drain_cnt_q;
        sel_i_d     = '0;
        sel_j_d     = '0;
        sel_k_d     = '0;
        acc_en_d    = 1'b0;
        acc_clr_d   = 1'b0;
        cf_load_d   = 1'b0;

        // An entry's last term (k=3) enters the store delay line as it issues
        pipe_vld_d[0] = acc_en_q && (sel_k_q == 2'd3);
        pipe_sel_d[0] = pipe_vld_d[0] ? (entry_q + 4'd1) : '0;
        for (int unsigned s = 1; s < MAC_LAT; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_sel_d[s] = pipe_sel_q[s-1];
        end

        case (state_q)
            S_LOAD: begin
                if (wr_en_w) begin
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d = S_COMP;
                        k_cnt_d = '0;
                        entry_d = '0;
                    end
                end
            end
            S_COMP: begin
                if (k_cnt_q == 2'd3 && entry_q == 4'd9) begin
                    // DRAIN spans the MAC_LAT-1 cycles before the last store;
                    // WAIT_OUT then coincides with that store.
                    if (MAC_LAT > 1) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = 3'(MAC_LAT - 2);
                    end else begin
                        state_d = S_WAIT_OUT;
                    end
                end else if (k_cnt_q == 2'd3) begin
                    k_cnt_d = '0;
                    entry_d = entry_q + 4'd1;
                end else begin
                    k_cnt_d = k_cnt_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = S_WAIT_OUT;
                end else begin
                    drain_cnt_d = drain_cnt_q - 3'd1;
                end
            end
            S_WAIT_OUT: begin
                if (!bus.out_busy) begin
                    state_d   = S_FIRE;
                    cf_load_d = 1'b1;
                end
            end
            S_FIRE: begin
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        // Operand set for the cycle being entered
        if (state_d == S_COMP) begin
            {sel_i_d, sel_j_d} = entry_pair(entry_d);
            sel_k_d            = k_cnt_d;
            acc_en_d           = 1'b1;
            acc_clr_d          = (k_cnt_d == 2'd0);
        end

        busy_d = (state_d != S_LOAD);
    end

    // State, counters, registered outputs and store delay line
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            load_cnt_q  <= '0;
            k_cnt_q     <= '0;
            entry_q     <= '0;
            drain_cnt_q <= '0;
            sel_i_q     <= '0;
            sel_j_q     <= '0;
            sel_k_q     <= '0;
            acc_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            cf_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            for (int unsigned s = 0; s < MAC_LAT; s++) begin
                pipe_vld_q[s] <= 1'b0;
                pipe_sel_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            k_cnt_q     <= k_cnt_d;
            entry_q     <= entry_d;
            drain_cnt_q <= drain_cnt_d;
            sel_i_q     <= sel_i_d;
            sel_j_q     <= sel_j_d;
            sel_k_q     <= sel_k_d;
            acc_en_q    <= acc_en_d;
            acc_clr_q   <= acc_clr_d;
            cf_load_q   <= cf_load_d;
            busy_q      <= busy_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_sel_q  <= pipe_sel_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.wr_en     = wr_en_w;
    assign bus.wr_addr   = load_cnt_q;
    assign bus.wr_data   = in_data_w;
    assign bus.sel_i     = sel_i_q;
    assign bus.sel_j     = sel_j_q;
    assign bus.sel_k     = sel_k_q;
    assign bus.acc_en    = acc_en_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.acc_store = pipe_vld_q[MAC_LAT-1];
    assign bus.store_sel = pipe_sel_q[MAC_LAT-1];
    assign bus.cf_load   = cf_load_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mm_compute_sequencer.sv
// Bench for mm_compute_sequencer: scoreboarded writes, issues and stores,
// a behavioural MAC datapath driven by the sequencer's controls, and
// golden A*A^T upper-triangle results computed from the driven matrix.
module tb_mm_compute_sequencer;
    localparam int DW      = 8;
    localparam int MAC_LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mm_compute_sequencer_if #(.DW(DW)) bus();

    mm_compute_sequencer #(.DW(DW), .MAC_LAT(MAC_LAT)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct {
        int off;
        int val;
    } exp_t;

    exp_t wr_q[$];
    exp_t iss_q[$];
    exp_t st_q[$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int  pair_i [10];
    int  pair_j [10];
    int  a_mem  [16];
    int  res    [16];
    int  acc;
    bit  dl_en  [8];
    bit  dl_clr [8];
    int  dl_term[8];
    int  c0;
    bit  c0_ok;
    int  wr_cnt, iss_cnt, st_cnt, stray;
    bit  fire_seen, post_fire;
    int  exp_fire_off;

    // Monitor: scoreboard pops, MAC datapath model, start-pulse checks
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            wr_q.delete(); iss_q.delete(); st_q.delete();
            wr_cnt = 0; c0_ok = 0; post_fire = 0; acc = 0;
            for (int m = 0; m < 8; m++) begin dl_en[m] = 0; dl_clr[m] = 0; dl_term[m] = 0; end
        end else begin
            if (bus.wr_en) begin
                if (wr_q.size() == 0) check_eq("wr_unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    check_eq("wr_addr", 32'(bus.wr_addr), e.off);
                    check_eq("wr_data", 32'(bus.wr_data), e.val);
                end
                a_mem[bus.wr_addr] = int'(bus.wr_data);
                wr_cnt++;
                if (wr_cnt == 16) begin
                    c0 = cyc + 1; c0_ok = 1; stray = 0; iss_cnt = 0; st_cnt = 0;
                    for (int p = 0; p < 10; p++) begin
                        for (int k = 0; k < 4; k++)
                            iss_q.push_back('{4*p + k, pair_i[p]*64 + pair_j[p]*16 + k*4 + ((k == 0) ? 1 : 0)});
                        st_q.push_back('{4*p + 3 + MAC_LAT, p + 1});
                    end
                end
            end
            if (c0_ok && cyc == c0) begin
                check_eq("rdy_drop_c0", 32'(bus.in_ready), 0);
                check_eq("busy_c0", 32'(bus.busy), 1);
            end
            if (bus.acc_en) begin
                if (iss_q.size() == 0) check_eq("issue_unexpected", 1, 0);
                else begin
                    e = iss_q.pop_front();
                    check_eq("issue_cyc", cyc - c0, e.off);
                    check_eq("issue_sel", int'(bus.sel_i)*64 + int'(bus.sel_j)*16 + int'(bus.sel_k)*4 + int'(bus.acc_clr), e.val);
                end
                iss_cnt++;
            end else if (bus.sel_i != 0 || bus.sel_j != 0 || bus.sel_k != 0 || bus.acc_clr) begin
                stray++;
            end
            if (bus.acc_store) begin
                if (st_q.size() == 0) check_eq("store_unexpected", 1, 0);
                else begin
                    e = st_q.pop_front();
                    check_eq("store_cyc", cyc - c0, e.off);
                    check_eq("store_sel", 32'(bus.store_sel), e.val);
                end
                st_cnt++;
            end else if (bus.store_sel != 0) begin
                stray++;
            end
            // MAC datapath: issue at cycle n lands in the accumulator at n+MAC_LAT
            if (dl_en[MAC_LAT-1]) acc = dl_clr[MAC_LAT-1] ? dl_term[MAC_LAT-1] : acc + dl_term[MAC_LAT-1];
            if (bus.acc_store) res[bus.store_sel] = acc;
            for (int m = MAC_LAT - 1; m > 0; m--) begin
                dl_en[m] = dl_en[m-1]; dl_clr[m] = dl_clr[m-1]; dl_term[m] = dl_term[m-1];
            end
            dl_en[0]   = bus.acc_en;
            dl_clr[0]  = bus.acc_clr;
            dl_term[0] = bus.acc_en ? a_mem[int'(bus.sel_i)*4 + int'(bus.sel_k)] * a_mem[int'(bus.sel_j)*4 + int'(bus.sel_k)] : 0;
            if (post_fire) begin
                check_eq("rdy_after_fire", 32'(bus.in_ready), 1);
                check_eq("busy_after_fire", 32'(bus.busy), 0);
                check_eq("cf_single", 32'(bus.cf_load), 0);
                post_fire = 0;
            end else if (bus.cf_load) begin
                check_eq("fire_cyc", c0_ok ? cyc - c0 : -1, exp_fire_off);
                check_eq("fire_issues", iss_cnt, 40);
                check_eq("fire_stores", st_cnt, 10);
                check_eq("fire_writes", wr_cnt, 16);
                check_eq("stray_ctrl", stray, 0);
                check_eq("busy_fire", 32'(bus.busy), 1);
                fire_seen = 1; post_fire = 1; wr_cnt = 0; c0_ok = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        check_eq({tag, "_ctrl"}, {20'd0, bus.wr_en, bus.busy, bus.sel_i, bus.sel_j, bus.sel_k,
                                  bus.acc_en, bus.acc_clr, bus.acc_store, bus.cf_load}, 0);
        check_eq({tag, "_store_sel"}, 32'(bus.store_sel), 0);
    endtask

    task automatic send_matrix(input int m[16], input bit gaps);
        int n;
        fire_seen = 0;
        for (int i = 0; i < 16; i++) res[i] = -1;
        for (int e = 0; e < 16; e++) begin
            if (gaps) begin bus.in_valid = 1'b0; tick(); end
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(m[e]);
            wr_q.push_back('{e, m[e] & 255});
            n = 0;
            while (!bus.in_ready && n < 200) begin tick(); n++; end
            if (n >= 200) check_eq("load_timeout", 0, 1);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc < target && n < 500) begin tick(); n++; end
        if (cyc < target) check_eq("wait_timeout", cyc, target);
    endtask

    task automatic wait_fire();
        int n = 0;
        while (!fire_seen && n < 500) begin tick(); n++; end
        check_eq("fire_seen", 32'(fire_seen), 1);
        repeat (3) tick();
    endtask

    task automatic check_golden(input string tag, input int m[16]);
        int p = 0;
        int s;
        for (int i = 0; i < 4; i++)
            for (int j = i; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += m[i*4 + k] * m[j*4 + k];
                check_eq($sformatf("%s_c%0d%0d", tag, i, j), res[p + 1], s);
                p++;
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m[16];
        int p = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i; j < 4; j++) begin pair_i[p] = i; pair_j[p] = j; p++; end

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_busy = 1'b0;
        exp_fire_off = 39 + MAC_LAT + 1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst_init");
        reset = 1'b0;
        tick();

        // Matrix abandoned by a reset in the middle of COMP
        for (int e = 0; e < 16; e++) m[e] = $urandom_range(0, 255);
        send_matrix(m, 1'b0);
        check_eq("c0_known", 32'(c0_ok), 1);
        wait_until(c0 + 10);
        reset = 1'b1;
        for (int r = 0; r < 3; r++) begin
            #1 check_reset_outputs($sformatf("rst_mid%0d", r));
            tick();
        end
        reset = 1'b0;
        tick();

        // Identity with in_valid toggling, plus ignored in_valid during COMP
        for (int e = 0; e < 16; e++) m[e] = (e % 5 == 0) ? 1 : 0;
        send_matrix(m, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        wait_fire();
        check_golden("ident", m);

        // All 2s, back-to-back load
        for (int e = 0; e < 16; e++) m[e] = 2;
        send_matrix(m, 1'b0);
        wait_fire();
        check_golden("twos", m);

        // Random matrix with the output controller busy until C50
        for (int e = 0; e < 16; e++) m[e] = $urandom_range(0, 255);
        bus.out_busy = 1'b1;
        exp_fire_off = 51;
        send_matrix(m, 1'b0);
        wait_until(c0 + 50);
        bus.out_busy = 1'b0;
        wait_fire();
        check_golden("busyhold", m);
        exp_fire_off = 39 + MAC_LAT + 1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
